// File: rtl/crossbar_config_arbiter.sv
// Round-robin arbiter that loads a crossbar select word: drain, load, settle, then pulse cfg_done.
// Accept to cfg_done takes 3+SETTLE cycles when the crossbar is idle; requesters stall until IDLE.
module crossbar_config_arbiter #(
  parameter int SEL_W  = 6,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_val,
  input  logic [SEL_W-1:0] req0_cfg,
  output logic             req0_rdy,
  input  logic             req1_val,
  input  logic [SEL_W-1:0] req1_cfg,
  output logic             req1_rdy,
  input  logic             xbar_busy,
  output logic [SEL_W-1:0] xbar_sel,
  output logic             xbar_gate,
  output logic             cfg_done,
  output logic             cfg_src
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_LOAD, ST_SETTLE} state_t;

  localparam bit         NO_SETTLE   = (SETTLE == 0);
  localparam logic [3:0] SETTLE_INIT = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t           state, state_nxt;
  logic             ptr;
  logic             grant;
  logic             accept;
  logic [SEL_W-1:0] pend_cfg;
  logic             pend_src;
  logic [SEL_W-1:0] sel_q;
  logic             src_q;
  logic [3:0]       cnt;
  logic             done_q;

  // Pointer only matters when both requesters are valid.
  assign grant    = (req0_val && req1_val) ? ptr : req1_val;
  assign accept   = (state == ST_IDLE) && (req0_val || req1_val);
  assign req0_rdy = (state == ST_IDLE) && req0_val && !grant;
  assign req1_rdy = (state == ST_IDLE) && req1_val && grant;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!xbar_busy) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = NO_SETTLE ? ST_IDLE : ST_SETTLE;
      ST_SETTLE: if (cnt == 4'd0) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ptr      <= 1'b0;
      pend_cfg <= '0;
      pend_src <= 1'b0;
      sel_q    <= '0;
      src_q    <= 1'b0;
      cnt      <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state_nxt == ST_IDLE) && (state != ST_IDLE);
      if (accept) begin
        pend_cfg <= grant ? req1_cfg : req0_cfg;
        pend_src <= grant;
        ptr      <= ~grant;
      end
      if (state == ST_LOAD) begin
        sel_q <= pend_cfg;
        src_q <= pend_src;
        cnt   <= SETTLE_INIT;
      end else if (state == ST_SETTLE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign xbar_sel  = sel_q;
  assign cfg_src   = src_q;
  assign xbar_gate = (state == ST_IDLE);
  assign cfg_done  = done_q;

endmodule

// File: tb/tb_crossbar_config_arbiter.sv
// Directed bench for crossbar_config_arbiter: default SETTLE instance plus a SETTLE=0 instance.
module tb_crossbar_config_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       r0v, r1v, busy;
  logic [5:0] r0c, r1c;
  logic       rdy0, rdy1, gate, done, src;
  logic [5:0] sel;

  logic       b0v, b1v, b_busy;
  logic [5:0] b0c, b1c;
  logic       b_rdy0, b_rdy1, b_gate, b_done, b_src;
  logic [5:0] b_sel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  crossbar_config_arbiter #(.SEL_W(6), .SETTLE(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_val(r0v), .req0_cfg(r0c), .req0_rdy(rdy0),
    .req1_val(r1v), .req1_cfg(r1c), .req1_rdy(rdy1),
    .xbar_busy(busy), .xbar_sel(sel), .xbar_gate(gate),
    .cfg_done(done), .cfg_src(src)
  );

  crossbar_config_arbiter #(.SEL_W(6), .SETTLE(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req0_val(b0v), .req0_cfg(b0c), .req0_rdy(b_rdy0),
    .req1_val(b1v), .req1_cfg(b1c), .req1_rdy(b_rdy1),
    .xbar_busy(b_busy), .xbar_sel(b_sel), .xbar_gate(b_gate),
    .cfg_done(b_done), .cfg_src(b_src)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    r0v = 1'b0; r1v = 1'b0; busy = 1'b0; r0c = '0; r1c = '0;
    b0v = 1'b0; b1v = 1'b0; b_busy = 1'b0; b0c = '0; b1c = '0;
    #1;
    chk6("rst_sel", sel, 6'h00);
    chk1("rst_gate", gate, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_src", src, 1'b0);
    chk1("rst_rdy0", rdy0, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // Single request, first cycle after reset release.
    r0v = 1'b1; r0c = 6'b001001;
    #1;
    chk1("s1_c0_rdy0", rdy0, 1'b1);
    chk1("s1_c0_rdy1", rdy1, 1'b0);
    chk1("s1_c0_gate", gate, 1'b1);
    step(); r0v = 1'b0; #1;
    chk1("s1_c1_gate", gate, 1'b0);
    chk6("s1_c1_sel", sel, 6'h00);
    step(); #1;
    chk1("s1_c2_gate", gate, 1'b0);
    chk6("s1_c2_sel", sel, 6'h00);
    step(); #1;
    chk6("s1_c3_sel", sel, 6'b001001);
    chk1("s1_c3_gate", gate, 1'b0);
    chk1("s1_c3_done", done, 1'b0);
    step(); #1;
    chk1("s1_c4_gate", gate, 1'b0);
    chk1("s1_c4_done", done, 1'b0);
    step(); #1;
    chk1("s1_c5_done", done, 1'b1);
    chk1("s1_c5_gate", gate, 1'b1);
    chk1("s1_c5_src", src, 1'b0);
    step(); #1;
    chk1("s1_c6_done", done, 1'b0);

    // Drain hold: busy high for four DRAIN cycles; val ignored outside IDLE.
    r1v = 1'b1; r1c = 6'h15; busy = 1'b1;
    #1;
    chk1("s2_c0_rdy1", rdy1, 1'b1);
    chk1("s2_c0_rdy0", rdy0, 1'b0);
    step(); r1v = 1'b0; r0v = 1'b1; r0c = 6'h0F; #1;
    chk1("s2_c1_gate", gate, 1'b0);
    chk1("s2_c1_rdy0", rdy0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      step(); #1;
      chk1("s2_drain_gate", gate, 1'b0);
      chk6("s2_drain_sel", sel, 6'b001001);
      chk1("s2_drain_rdy0", rdy0, 1'b0);
    end
    step(); busy = 1'b0; r0v = 1'b0; #1;
    chk1("s2_c5_gate", gate, 1'b0);
    chk6("s2_c5_sel", sel, 6'b001001);
    step(); #1;
    chk6("s2_c6_sel", sel, 6'b001001);
    chk1("s2_c6_gate", gate, 1'b0);
    step(); #1;
    chk6("s2_c7_sel", sel, 6'h15);
    chk1("s2_c7_src", src, 1'b1);
    step(); #1;
    chk1("s2_c8_done", done, 1'b0);
    chk1("s2_c8_gate", gate, 1'b0);
    step(); #1;
    chk1("s2_c9_done", done, 1'b1);
    chk1("s2_c9_gate", gate, 1'b1);
    step(); #1;
    chk1("s2_c10_done", done, 1'b0);

    // Contention: both valid continuously, back-to-back accepts alternate.
    r0v = 1'b1; r0c = 6'h01; r1v = 1'b1; r1c = 6'h02;
    #1;
    chk1("s3_k0_rdy0", rdy0, 1'b1);
    chk1("s3_k0_rdy1", rdy1, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      step(); #1;
      chk1("s3_dual_rdy", rdy0 & rdy1, 1'b0);
      if (k == 5) begin
        chk1("s3_k5_done", done, 1'b1);
        chk6("s3_k5_sel", sel, 6'h01);
        chk1("s3_k5_src", src, 1'b0);
        chk1("s3_k5_rdy1", rdy1, 1'b1);
      end else if (k == 10) begin
        chk1("s3_k10_done", done, 1'b1);
        chk6("s3_k10_sel", sel, 6'h02);
        chk1("s3_k10_src", src, 1'b1);
        chk1("s3_k10_rdy0", rdy0, 1'b1);
      end else if (k == 15) begin
        chk1("s3_k15_done", done, 1'b1);
        chk6("s3_k15_sel", sel, 6'h01);
        chk1("s3_k15_src", src, 1'b0);
        chk1("s3_k15_rdy1", rdy1, 1'b1);
      end else begin
        chk1("s3_gate_low", gate, 1'b0);
      end
    end
    r0v = 1'b0; r1v = 1'b0;
    step(); #1;
    chk1("s3_end_gate", gate, 1'b1);
    chk1("s3_end_done", done, 1'b0);

    // Reset asserted mid-SETTLE discards the sequence.
    r0v = 1'b1; r0c = 6'h2A;
    #1;
    chk1("s4_c0_rdy0", rdy0, 1'b1);
    step(); r0v = 1'b0;
    step();
    step(); #1;
    chk6("s4_c3_sel", sel, 6'h2A);
    chk1("s4_c3_gate", gate, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk6("s4_rst_sel", sel, 6'h00);
    chk1("s4_rst_gate", gate, 1'b1);
    chk1("s4_rst_done", done, 1'b0);
    chk1("s4_rst_src", src, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk1("s4_no_done", done, 1'b0);
      chk1("s4_idle_gate", gate, 1'b1);
    end
    r1v = 1'b1; r1c = 6'h33;
    #1;
    chk1("s4_new_rdy1", rdy1, 1'b1);
    step(); r1v = 1'b0;
    repeat (4) step();
    #1;
    chk1("s4_new_done", done, 1'b1);
    chk6("s4_new_sel", sel, 6'h33);
    chk1("s4_new_src", src, 1'b1);

    // SETTLE=0 instance: LOAD returns straight to IDLE.
    b0v = 1'b1; b0c = 6'h3C;
    #1;
    chk1("s5_c0_rdy0", b_rdy0, 1'b1);
    step(); b0v = 1'b0; #1;
    chk1("s5_c1_gate", b_gate, 1'b0);
    step(); #1;
    chk1("s5_c2_gate", b_gate, 1'b0);
    chk1("s5_c2_done", b_done, 1'b0);
    chk6("s5_c2_sel", b_sel, 6'h00);
    step(); #1;
    chk1("s5_c3_done", b_done, 1'b1);
    chk1("s5_c3_gate", b_gate, 1'b1);
    chk6("s5_c3_sel", b_sel, 6'h3C);
    chk1("s5_c3_src", b_src, 1'b0);
    step(); #1;
    chk1("s5_c4_done", b_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
